// File: rtl/tcp_header_tx.sv
// tcp_header_tx: serializes a 20-byte TCP header MSB-first onto an
// 8-bit valid/ready byte stream, tx_last on byte 19.
// Ports: clk, rst_n (async, active low);
//   header side: hdr_valid/hdr_ready, src_port, dst_port, seq_num,
//     ack_num, flags, window_size, checksum_in, urgent_ptr, pseudo_sum;
//   stream side: tx_data, tx_valid, tx_ready, tx_last;
//   hdr_done: one-cycle pulse after the byte-19 beat.
// Macro TCP_TX_CSUM_EN: compute the checksum in-line from pseudo_sum
//   instead of forwarding checksum_in.
module tcp_header_tx #(
    parameter logic [3:0]  DATA_OFFSET = 4'd5,
    parameter int unsigned MIN_GAP     = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hdr_valid,
    output logic        hdr_ready,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [31:0] seq_num,
    input  logic [31:0] ack_num,
    input  logic [8:0]  flags,
    input  logic [15:0] window_size,
    input  logic [15:0] checksum_in,
    input  logic [15:0] urgent_ptr,
    input  logic [15:0] pseudo_sum,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        tx_last,
    output logic        hdr_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    logic [1:0]   state;
    logic [4:0]   byte_cnt;
    logic [3:0]   gap_cnt;
    logic         valid_q;
    logic         done_q;
    logic [15:0]  src_q;
    logic [15:0]  dst_q;
    logic [31:0]  seq_q;
    logic [31:0]  ack_q;
    logic [8:0]   flags_q;
    logic [15:0]  win_q;
    logic [15:0]  urg_q;
    logic [15:0]  csum_field;
    logic [159:0] hdr_vec;
    logic [7:0]   byte_lsb;
    logic         capture;
    logic         beat;
    logic         last_beat;

    // hdr_ready is gated by rst_n so it reads 0 during reset
    assign hdr_ready = rst_n && (state == S_IDLE);
    assign capture   = hdr_valid && hdr_ready;
    assign beat      = valid_q && tx_ready;
    assign last_beat = beat && (byte_cnt == 5'd19);

    // Whole header as one vector, byte 0 in the top bits
    assign hdr_vec = {src_q, dst_q, seq_q, ack_q,
                      DATA_OFFSET, 3'b000, flags_q,
                      win_q, csum_field, urg_q};

    assign byte_lsb = {5'd19 - byte_cnt, 3'b000};
    assign tx_data  = valid_q ? hdr_vec[byte_lsb +: 8] : 8'h00;
    assign tx_valid = valid_q;
    assign tx_last  = valid_q && (byte_cnt == 5'd19);
    assign hdr_done = done_q;

`ifdef TCP_TX_CSUM_EN
    logic [15:0] acc;
    logic [16:0] seed_sum;
    logic [16:0] add_sum;
    logic [7:0]  word_lsb;
    logic [15:0] cur_word;
    logic        add_en;
    logic        unused_csum_in;

    assign unused_csum_in = ^checksum_in;

    // Word being completed by the current (odd) byte
    assign word_lsb = {4'd9 - byte_cnt[4:1], 4'b0000};
    assign cur_word = hdr_vec[word_lsb +: 16];
    assign seed_sum = {1'b0, pseudo_sum} + {1'b0, urgent_ptr};
    assign add_sum  = {1'b0, acc} + {1'b0, cur_word};
    // Words 0..7 only; the checksum word itself counts as zero
    assign add_en   = beat && byte_cnt[0] && (byte_cnt < 5'd16);

    // End-around carry on every addition
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (capture) begin
            acc <= seed_sum[15:0] + 16'(seed_sum[16]);
        end else if (add_en) begin
            acc <= add_sum[15:0] + 16'(add_sum[16]);
        end
    end

    assign csum_field = ~acc;
`else
    logic [15:0] csum_q;
    logic        unused_pseudo;

    assign unused_pseudo = ^pseudo_sum;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum_q <= '0;
        end else if (capture) begin
            csum_q <= checksum_in;
        end
    end

    assign csum_field = csum_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_q   <= '0;
            dst_q   <= '0;
            seq_q   <= '0;
            ack_q   <= '0;
            flags_q <= '0;
            win_q   <= '0;
            urg_q   <= '0;
        end else if (capture) begin
            src_q   <= src_port;
            dst_q   <= dst_port;
            seq_q   <= seq_num;
            ack_q   <= ack_num;
            flags_q <= flags;
            win_q   <= window_size;
            urg_q   <= urgent_ptr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            byte_cnt <= '0;
            gap_cnt  <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= last_beat;
            unique case (state)
                S_IDLE: begin
                    if (capture) begin
                        byte_cnt <= '0;
                        valid_q  <= 1'b1;
                        state    <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (last_beat) begin
                        byte_cnt <= '0;
                        valid_q  <= 1'b0;
                        if (MIN_GAP > 0) begin
                            gap_cnt <= 4'(MIN_GAP - 1);
                            state   <= S_GAP;
                        end else begin
                            state   <= S_IDLE;
                        end
                    end else if (beat) begin
                        byte_cnt <= byte_cnt + 5'd1;
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt - 4'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_header_tx.sv
// tb_tcp_header_tx: randomized and directed stimulus for tcp_header_tx,
// checked against a field-level model of the 20-byte header.
module tb_tcp_header_tx;

    typedef struct packed {
        logic [15:0] src;
        logic [15:0] dst;
        logic [31:0] seq;
        logic [31:0] ack;
        logic [8:0]  flags;
        logic [15:0] win;
        logic [15:0] csum;
        logic [15:0] urg;
        logic [15:0] pseudo;
    } hdr_t;

    logic        clk;
    logic        rst_n;
    logic        hdr_valid;
    logic        hdr_ready;
    logic [15:0] src_port;
    logic [15:0] dst_port;
    logic [31:0] seq_num;
    logic [31:0] ack_num;
    logic [8:0]  flags;
    logic [15:0] window_size;
    logic [15:0] checksum_in;
    logic [15:0] urgent_ptr;
    logic [15:0] pseudo_sum;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        tx_last;
    logic        hdr_done;

    int checks;
    int errors;
    int cyc;
    int done_cnt;

    logic [7:0] exp_b [20];
    logic [7:0] rx_b  [20];
    logic       rx_l  [20];
    int rx_n;
    int stall_bad;
    int last_edge;
    int cap_edge;
    bit cap_ok;
    int bad_idx;

    tcp_header_tx dut (
        .clk(clk),
        .rst_n(rst_n),
        .hdr_valid(hdr_valid),
        .hdr_ready(hdr_ready),
        .src_port(src_port),
        .dst_port(dst_port),
        .seq_num(seq_num),
        .ack_num(ack_num),
        .flags(flags),
        .window_size(window_size),
        .checksum_in(checksum_in),
        .urgent_ptr(urgent_ptr),
        .pseudo_sum(pseudo_sum),
        .tx_data(tx_data),
        .tx_valid(tx_valid),
        .tx_ready(tx_ready),
        .tx_last(tx_last),
        .hdr_done(hdr_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (hdr_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    // Reference: header bytes from fields; checksum as a plain
    // 32-bit sum folded once at the end.
    function automatic void fill_exp(input hdr_t h);
        int unsigned s;
        logic [15:0] c;
        exp_b[0]  = h.src[15:8];
        exp_b[1]  = h.src[7:0];
        exp_b[2]  = h.dst[15:8];
        exp_b[3]  = h.dst[7:0];
        exp_b[4]  = h.seq[31:24];
        exp_b[5]  = h.seq[23:16];
        exp_b[6]  = h.seq[15:8];
        exp_b[7]  = h.seq[7:0];
        exp_b[8]  = h.ack[31:24];
        exp_b[9]  = h.ack[23:16];
        exp_b[10] = h.ack[15:8];
        exp_b[11] = h.ack[7:0];
        exp_b[12] = {4'd5, 3'b000, h.flags[8]};
        exp_b[13] = h.flags[7:0];
        exp_b[14] = h.win[15:8];
        exp_b[15] = h.win[7:0];
        exp_b[18] = h.urg[15:8];
        exp_b[19] = h.urg[7:0];
`ifdef TCP_TX_CSUM_EN
        s = 32'(h.pseudo) + 32'(h.urg);
        for (int w = 0; w < 8; w++)
            s = s + 32'({exp_b[2*w], exp_b[2*w+1]});
        while (s > 32'hFFFF)
            s = (s & 32'hFFFF) + (s >> 16);
        c = ~s[15:0];
`else
        c = h.csum;
`endif
        exp_b[16] = c[15:8];
        exp_b[17] = c[7:0];
    endfunction

    function automatic int frame_errs();
        int n;
        logic want_l;
        n = 0;
        bad_idx = -1;
        for (int i = 0; i < 20; i++) begin
            want_l = (i == 19);
            if (rx_b[i] !== exp_b[i] || rx_l[i] !== want_l) begin
                n++;
                if (bad_idx < 0) bad_idx = i;
            end
        end
        if (bad_idx < 0) bad_idx = 0;
        return n;
    endfunction

    function automatic hdr_t rand_hdr();
        hdr_t h;
        h.src    = 16'($urandom);
        h.dst    = 16'($urandom);
        h.seq    = $urandom;
        h.ack    = $urandom;
        h.flags  = 9'($urandom);
        h.win    = 16'($urandom);
        h.csum   = 16'($urandom);
        h.urg    = 16'($urandom);
        h.pseudo = 16'($urandom);
        return h;
    endfunction

    function automatic hdr_t t1_hdr();
        hdr_t h;
        h.src    = 16'h1234;
        h.dst    = 16'h0050;
        h.seq    = 32'd1;
        h.ack    = 32'd0;
        h.flags  = 9'h002;
        h.win    = 16'hFFFF;
        h.csum   = 16'hBEEF;
        h.urg    = 16'h0000;
        h.pseudo = 16'h0000;
        return h;
    endfunction

    task automatic drive(input hdr_t h);
        src_port    = h.src;
        dst_port    = h.dst;
        seq_num     = h.seq;
        ack_num     = h.ack;
        flags       = h.flags;
        window_size = h.win;
        checksum_in = h.csum;
        urgent_ptr  = h.urg;
        pseudo_sum  = h.pseudo;
    endtask

    // Called at a negedge; returns at the negedge before the capture edge
    task automatic capture(input hdr_t h);
        int g;
        g = 0;
        drive(h);
        hdr_valid = 1'b1;
        while (hdr_ready !== 1'b1 && g < 50) begin
            @(negedge clk);
            g++;
        end
        cap_ok   = (hdr_ready === 1'b1);
        cap_edge = cyc + 1;
    endtask

    // Collects bytes at negedges; mode 0: ready=1, 1: random,
    // 2: 3-cycle stalls at bytes 0, 7 and 19.
    task automatic recv(input int mode, input int n_stop);
        int guard;
        int st;
        logic [7:0] hd;
        logic hl;
        bit hold;
        bit r;
        rx_n = 0;
        stall_bad = 0;
        guard = 0;
        st = 0;
        hold = 0;
        hd = '0;
        hl = 1'b0;
        for (int i = 0; i < 20; i++) begin
            rx_b[i] = 'x;
            rx_l[i] = 1'bx;
        end
        forever begin
            if (tx_valid === 1'b1) begin
                if (hold && (tx_data !== hd || tx_last !== hl))
                    stall_bad++;
                r = 1'b1;
                if (mode == 1) begin
                    r = ($urandom_range(0, 1) == 1);
                end else if (mode == 2 && st < 3 &&
                             (rx_n == 0 || rx_n == 7 || rx_n == 19)) begin
                    r = 1'b0;
                    st++;
                end
                tx_ready = r;
                if (r) begin
                    rx_b[rx_n] = tx_data;
                    rx_l[rx_n] = tx_last;
                    rx_n++;
                    last_edge = cyc + 1;
                    hold = 0;
                    st = 0;
                end else begin
                    hold = 1;
                    hd = tx_data;
                    hl = tx_last;
                end
            end else begin
                if (hold) stall_bad++;
                hold = 0;
                tx_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (rx_n >= n_stop || guard >= 400) break;
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic test_reset();
        hdr_t z;
        z = '0;
        rst_n = 1'b0;
        hdr_valid = 1'b0;
        tx_ready = 1'b0;
        drive(z);
        repeat (3) @(negedge clk);
        checks++;
        if (hdr_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_hdr_ready: got %b want 0", hdr_ready);
        end
        checks++;
        if (tx_valid !== 1'b0 || tx_last !== 1'b0) begin
            errors++;
            $display("FAIL reset_tx: valid=%b last=%b want 0/0",
                     tx_valid, tx_last);
        end
        checks++;
        if (tx_data !== 8'h00 || hdr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_data: data=%h done=%b want 00/0",
                     tx_data, hdr_done);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: hdr_ready=%b want 1", hdr_ready);
        end
    endtask

    task automatic test_basic();
        hdr_t h;
        h = t1_hdr();
        fill_exp(h);
        capture(h);
        checks++;
        if (!cap_ok) begin
            errors++;
            $display("FAIL basic_capture: hdr_ready=%b want 1", hdr_ready);
        end
        @(negedge clk);
        hdr_valid = 1'b0;
        checks++;
        if (tx_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency: tx_valid=%b want 1", tx_valid);
        end
        recv(0, 20);
        checks++;
        if (frame_errs() != 0) begin
            errors++;
            $display("FAIL basic_bytes: byte %0d got %h/%b want %h, rx_n=%0d",
                     bad_idx, rx_b[bad_idx], rx_l[bad_idx],
                     exp_b[bad_idx], rx_n);
        end
        checks++;
`ifdef TCP_TX_CSUM_EN
        if ({rx_b[16], rx_b[17]} !== 16'h9D78) begin
            errors++;
            $display("FAIL basic_csum: got %h%h want 9d78",
                     rx_b[16], rx_b[17]);
        end
`else
        if ({rx_b[16], rx_b[17]} !== 16'hBEEF) begin
            errors++;
            $display("FAIL basic_csum: got %h%h want beef",
                     rx_b[16], rx_b[17]);
        end
`endif
        @(negedge clk);
        checks++;
        if (hdr_done !== 1'b1 || tx_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_done: done=%b valid=%b want 1/0",
                     hdr_done, tx_valid);
        end
        @(negedge clk);
        checks++;
        if (hdr_done !== 1'b0 || hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_idle: done=%b ready=%b want 0/1",
                     hdr_done, hdr_ready);
        end
    endtask

    task automatic test_carry_fold();
        hdr_t h;
        h = '0;
        h.pseudo = 16'hFFFF;
        fill_exp(h);
        capture(h);
        @(negedge clk);
        hdr_valid = 1'b0;
        recv(0, 20);
        checks++;
        if (frame_errs() != 0) begin
            errors++;
            $display("FAIL fold_bytes: byte %0d got %h want %h, rx_n=%0d",
                     bad_idx, rx_b[bad_idx], exp_b[bad_idx], rx_n);
        end
`ifdef TCP_TX_CSUM_EN
        checks++;
        if ({rx_b[16], rx_b[17]} !== 16'hAFFF) begin
            errors++;
            $display("FAIL fold_csum: got %h%h want afff",
                     rx_b[16], rx_b[17]);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_backpressure();
        hdr_t h;
        h = t1_hdr();
        fill_exp(h);
        capture(h);
        @(negedge clk);
        hdr_valid = 1'b0;
        recv(2, 20);
        checks++;
        if (frame_errs() != 0) begin
            errors++;
            $display("FAIL bp_bytes: byte %0d got %h want %h, rx_n=%0d",
                     bad_idx, rx_b[bad_idx], exp_b[bad_idx], rx_n);
        end
        checks++;
        if (stall_bad != 0) begin
            errors++;
            $display("FAIL bp_stable: %0d unstable stall cycles want 0",
                     stall_bad);
        end
        @(negedge clk);
        checks++;
        if (hdr_done !== 1'b1) begin
            errors++;
            $display("FAIL bp_done: hdr_done=%b want 1", hdr_done);
        end
    endtask

    task automatic test_random();
        hdr_t h;
        for (int k = 0; k < 8; k++) begin
            h = rand_hdr();
            fill_exp(h);
            capture(h);
            @(negedge clk);
            hdr_valid = 1'b0;
            recv(1, 20);
            checks++;
            if (frame_errs() != 0 || stall_bad != 0) begin
                errors++;
                $display("FAIL rand_%0d: byte %0d got %h want %h, stalls=%0d",
                         k, bad_idx, rx_b[bad_idx], exp_b[bad_idx],
                         stall_bad);
            end
            @(negedge clk);
            checks++;
            if (hdr_done !== 1'b1 || tx_valid !== 1'b0) begin
                errors++;
                $display("FAIL rand_done_%0d: done=%b valid=%b want 1/0",
                         k, hdr_done, tx_valid);
            end
            tx_ready = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        hdr_t ha;
        hdr_t hb;
        int cap_a;
        int last_a;
        int cap_b;
        ha = rand_hdr();
        hb = rand_hdr();
        capture(ha);
        cap_a = cap_edge;
        @(negedge clk);
        drive(hb);
        recv(0, 20);
        last_a = last_edge;
        fill_exp(ha);
        checks++;
        if (frame_errs() != 0) begin
            errors++;
            $display("FAIL b2b_first: byte %0d got %h want %h, rx_n=%0d",
                     bad_idx, rx_b[bad_idx], exp_b[bad_idx], rx_n);
        end
        @(negedge clk);
        cap_b = cyc + 1;
        checks++;
        if (hdr_ready !== 1'b1 || hdr_done !== 1'b1) begin
            errors++;
            $display("FAIL b2b_gap: ready=%b done=%b want 1/1",
                     hdr_ready, hdr_done);
        end
        checks++;
        if (cap_b - last_a != 1) begin
            errors++;
            $display("FAIL b2b_capture: %0d cycles after last beat want 1",
                     cap_b - last_a);
        end
        @(negedge clk);
        hdr_valid = 1'b0;
        recv(0, 20);
        fill_exp(hb);
        checks++;
        if (frame_errs() != 0) begin
            errors++;
            $display("FAIL b2b_second: byte %0d got %h want %h, rx_n=%0d",
                     bad_idx, rx_b[bad_idx], exp_b[bad_idx], rx_n);
        end
        checks++;
        if (last_edge - cap_a != 41) begin
            errors++;
            $display("FAIL b2b_span: %0d cycles want 41",
                     last_edge - cap_a);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        hdr_t h;
        int dc;
        h = rand_hdr();
        capture(h);
        @(negedge clk);
        hdr_valid = 1'b0;
        recv(0, 10);
        @(posedge clk);
        #2;
        dc = done_cnt;
        rst_n = 1'b0;
        #1;
        checks++;
        if (tx_valid !== 1'b0 || tx_last !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset_drop: valid=%b last=%b want 0/0",
                     tx_valid, tx_last);
        end
        tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (hdr_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_reset_ready: hdr_ready=%b want 1", hdr_ready);
        end
        checks++;
        if (done_cnt != dc) begin
            errors++;
            $display("FAIL mid_reset_done: %0d hdr_done pulses want 0",
                     done_cnt - dc);
        end
        h = rand_hdr();
        fill_exp(h);
        capture(h);
        @(negedge clk);
        hdr_valid = 1'b0;
        recv(0, 20);
        checks++;
        if (frame_errs() != 0) begin
            errors++;
            $display("FAIL mid_reset_next: byte %0d got %h want %h, rx_n=%0d",
                     bad_idx, rx_b[bad_idx], exp_b[bad_idx], rx_n);
        end
        @(negedge clk);
    endtask

    initial begin
        clk = 1'b0;
        cyc = 0;
        done_cnt = 0;
        checks = 0;
        errors = 0;
        last_edge = 0;
        cap_edge = 0;
        test_reset();
        test_basic();
        test_carry_fold();
        test_backpressure();
        test_random();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
